// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS opcodes, fetch-state encoding and PC helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [5:0] R    = 6'h00;
  localparam logic [5:0] ADDI = 6'h08;
  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] SW   = 6'h2B;
  localparam logic [5:0] ANDI = 6'h0C;
  localparam logic [5:0] BEQ  = 6'h04;
  localparam logic [5:0] JAL  = 6'h03;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Pseudo-direct jump target inside the current 256 MB region.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] target);
    return {pc_plus4[31:28], target, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory request/response bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_logic
// Description : Combinational next-PC select: jump, taken branch or PC+4.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  // The opcode field is decoded upstream; only the immediate fields matter here.
  logic w_unused_opcode;
  assign w_unused_opcode = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target(pc_plus4, instr[25:0]);
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset(instr[15:0]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Multi-cycle instruction fetch: PC, instruction register,
//               IDLE/FETCH/EXEC sequencer and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc_plus4,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  input  logic               exec_done,
  output logic [31:0]        instr_count
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_EXEC  = EXEC;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_count;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;

  next_pc_logic u_next_pc (
    .pc_plus4 (w_pc_plus4),
    .instr    (r_instr),
    .branch   (branch),
    .jump     (jump),
    .zero     (zero),
    .next_pc  (w_next_pc)
  );

  // Inputs outside their owning state fall through the case untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC_ALIGNED;
      r_instr <= 32'h0000_0000;
      r_count <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem.imem_ready) begin
            r_instr <= imem.imem_rdata;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            r_pc    <= w_next_pc;
            r_count <= r_count + 32'd1;
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs are suppressed while rst is high so an abort is clean.
  assign imem.imem_req  = (r_state == ST_FETCH) && !rst;
  assign imem.imem_addr = r_pc;
  assign instr_valid    = (r_state == ST_EXEC) && !rst;
  assign instr          = r_instr;
  assign pc_plus4       = w_pc_plus4;
  assign instr_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit driven by a directed program.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic        branch;
  logic        jump;
  logic        zero;
  logic        exec_done;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_plus4    (pc_plus4),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .exec_done   (exec_done),
    .instr_count (instr_count)
  );

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h1000_FFFE;
      32'h0000_0004: return 32'h0BFF_FFFF;
      32'h0000_0008: return 32'h8C01_0004;
      32'h0000_000C: return 32'hAC01_0008;
      32'h0000_0010: return 32'h1000_FFFE;
      32'h0000_0014: return 32'h1000_FFFA;
      32'hFFFF_FFFC: return 32'h0000_0020;
      32'h0FFF_FFFC: return 32'h0BFF_FFFF;
      32'h1FFF_FFFC: return 32'h0BFF_FFFF;
      32'h2FFF_FFFC: return 32'h0BFF_FFFF;
      32'h3FFF_FFFC: return 32'h0800_0008;
      32'h4000_0020: return 32'h0C00_0100;
      32'h4000_0400: return 32'h2008_0005;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  assign bus.imem_rdata = mem_read(bus.imem_addr);
  assign bus.imem_ready = ready;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [31:0] count;
  } exec_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        br;
    logic        jmp;
    logic        z;
    int          waits;
  } entry_t;

  logic [31:0] exp_addr_q[$];
  exec_exp_t   exp_exec_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT accepts a fetch or enters EXEC.
  logic        prev_valid = 1'b0;
  logic [31:0] mon_addr;
  exec_exp_t   mon_exec;
  always @(negedge clk) begin
    if (bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fetch_addr: unexpected fetch at %08h expected none", bus.imem_addr);
      end else begin
        mon_addr = exp_addr_q.pop_front();
        check32("fetch_addr", bus.imem_addr, mon_addr);
      end
    end
    if (instr_valid === 1'b1 && !prev_valid) begin
      if (exp_exec_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL exec_entry: unexpected EXEC with instr %08h expected none", instr);
      end else begin
        mon_exec = exp_exec_q.pop_front();
        check32("exec_instr", instr, mon_exec.instr);
        check32("exec_pc_plus4", pc_plus4, mon_exec.pc_plus4);
        check32("exec_count", instr_count, mon_exec.count);
      end
    end
    prev_valid = (instr_valid === 1'b1);
  end

  function automatic entry_t mk(input logic [31:0] a, input logic [31:0] i,
                                input logic b, input logic j, input logic z, input int w);
    entry_t e;
    e.addr = a; e.instr = i; e.br = b; e.jmp = j; e.z = z; e.waits = w;
    return e;
  endfunction

  // Issue one fetch/execute; optionally abort it with rst in the exec_done cycle.
  task automatic run_entry(input entry_t e, input logic [31:0] prev_instr, input bit use_reset);
    exec_exp_t x;
    int n;
    exp_addr_q.push_back(e.addr);
    x.instr    = e.instr;
    x.pc_plus4 = e.addr + 32'd4;
    x.count    = exp_count;
    exp_exec_q.push_back(x);
    if (e.waits > 0) begin
      ready     = 1'b0;
      exec_done = 1'b1;
      for (int k = 0; k < e.waits; k++) begin
        @(negedge clk);
        check32("wait_req", 32'(bus.imem_req), 32'h1);
        check32("wait_addr", bus.imem_addr, e.addr);
        check32("wait_instr", instr, prev_instr);
        check32("wait_count", instr_count, exp_count);
        @(posedge clk); #1;
      end
      exec_done = 1'b0;
      ready     = 1'b1;
    end
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL exec_timeout: got no EXEC for %08h expected EXEC within 20 cycles", e.addr);
    end
    @(negedge clk);
    check32("exec_req", 32'(bus.imem_req), 32'h0);
    @(posedge clk); #1;
    branch    = e.br;
    jump      = e.jmp;
    zero      = e.z;
    exec_done = 1'b1;
    if (use_reset) rst = 1'b1;
    @(negedge clk);
    check32("exec_hold", instr, e.instr);
    @(posedge clk); #1;
    exec_done = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    zero      = 1'b0;
    if (!use_reset) exp_count = exp_count + 32'd1;
  endtask

  entry_t tbl[17];

  initial begin
    tbl[0]  = mk(32'h0000_0000, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 0);
    tbl[1]  = mk(32'h0000_0004, 32'h0BFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
    tbl[2]  = mk(32'h0000_0008, 32'h8C01_0004, 1'b0, 1'b0, 1'b0, 0);
    tbl[3]  = mk(32'h0000_000C, 32'hAC01_0008, 1'b0, 1'b0, 1'b0, 0);
    tbl[4]  = mk(32'h0000_0010, 32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 0);
    tbl[5]  = mk(32'h0000_000C, 32'hAC01_0008, 1'b0, 1'b0, 1'b0, 0);
    tbl[6]  = mk(32'h0000_0010, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 0);
    tbl[7]  = mk(32'h0000_0014, 32'h1000_FFFA, 1'b1, 1'b0, 1'b1, 0);
    tbl[8]  = mk(32'h0000_0000, 32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 0);
    tbl[9]  = mk(32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 3);
    tbl[10] = mk(32'h0000_0000, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 0);
    tbl[11] = mk(32'h0000_0004, 32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
    tbl[12] = mk(32'h0FFF_FFFC, 32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
    tbl[13] = mk(32'h1FFF_FFFC, 32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
    tbl[14] = mk(32'h2FFF_FFFC, 32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
    tbl[15] = mk(32'h3FFF_FFFC, 32'h0800_0008, 1'b0, 1'b1, 1'b0, 0);
    tbl[16] = mk(32'h4000_0020, 32'h0C00_0100, 1'b1, 1'b1, 1'b1, 0);

    rst = 1'b1; ready = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0; exec_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_req", 32'(bus.imem_req), 32'h0);
    check32("rst_valid", 32'(instr_valid), 32'h0);
    check32("rst_instr", instr, 32'h0);
    check32("rst_count", instr_count, 32'h0);
    check32("rst_addr", bus.imem_addr, 32'h0);
    check32("rst_pc_plus4", pc_plus4, 32'h4);
    @(posedge clk); #1;
    rst   = 1'b0;
    ready = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_entry(tbl[i], (i > 0) ? tbl[i-1].instr : 32'h0, 1'b0);
      if (i == 2) begin
        @(negedge clk);
        check32("count_after_three", instr_count, 32'd3);
      end
    end

    // Abort an EXEC with rst and exec_done together.
    run_entry(mk(32'h4000_0400, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 0), tbl[16].instr, 1'b1);
    @(negedge clk);
    check32("abort_addr", bus.imem_addr, 32'h0);
    check32("abort_count", instr_count, 32'h0);
    check32("abort_valid", 32'(instr_valid), 32'h0);
    check32("abort_instr", instr, 32'h0);
    exp_count = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_entry(mk(32'h0000_0000, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 0), 32'h0, 1'b0);
    ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("final_count", instr_count, 32'd1);
    check32("final_addr", bus.imem_addr, 32'h4);
    check32("addr_queue_empty", 32'(exp_addr_q.size()), 32'h0);
    check32("exec_queue_empty", 32'(exp_exec_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address, equal to current PC.
REQ-006 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-007 imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle.
REQ-008 instr  output  32  instruction register; instr[31:26] drives the control unit Opcode.
REQ-009 instr_valid  output  1  instr holds a fetched instruction awaiting execution.
REQ-010 pc_plus4  output  32  current PC + 4; JAL link value for the register-file write mux.
REQ-011 branch  input  1  Branch from control unit.
REQ-012 jump  input  1  Jump from control unit.
REQ-013 zero  input  1  ALU zero flag.
REQ-014 exec_done  input  1  one-cycle pulse; datapath retired the current instruction.
REQ-015 instr_count  output  32  retired-instruction counter.

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH and EXEC.
REQ-017 IDLE SHALL go to FETCH on the first cycle after rst deasserts.
REQ-018 In FETCH: imem_req=1 and imem_addr=PC; on imem_ready=1 the block SHALL load instr from imem_rdata and go to EXEC on the next edge.
REQ-019 A zero-wait fetch SHALL be supported: request and ready in the same cycle gives a one-cycle fetch.
REQ-020 In FETCH with imem_ready=0: the block SHALL hold state, PC and imem_addr stable, and keep imem_req asserted.
REQ-021 In EXEC: instr_valid=1, imem_req=0, and instr SHALL be held stable.
REQ-022 In EXEC on exec_done=1: PC SHALL load next_pc, instr_count SHALL increment by 1, and the FSM SHALL go to FETCH.
REQ-023 next_pc if jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-024 next_pc else if branch=1 and zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), modulo 2^32.
REQ-025 next_pc otherwise: pc_plus4.
REQ-026 When jump and branch are both set, jump SHALL take priority.
REQ-027 PC arithmetic SHALL wrap modulo 2^32; PC=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000.
REQ-028 PC[1:0] SHALL always be 2'b00, with low bits of RESET_PC forced to 0.
REQ-029 imem_ready outside FETCH and exec_done outside EXEC SHALL be ignored.
REQ-030 instr_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 instr_valid SHALL be 1 only in EXEC.

Reset
REQ-032 While rst=1 the block SHALL hold: state=IDLE, PC=RESET_PC, instr=0, instr_valid=0, imem_req=0, instr_count=0.
REQ-033 While rst=1, pc_plus4 SHALL be RESET_PC+4.
REQ-034 rst asserted mid-fetch or mid-execute SHALL abort the operation at the next edge, with no PC update and no count increment.
REQ-035 rst SHALL take priority over exec_done and imem_ready in the same cycle.

Structure
REQ-036 The shared package mips_pkg SHALL hold the opcode constants R, ADDI, LW, SW, ANDI, BEQ, JAL, the fetch-state enum, and the default RESET_PC.
REQ-037 The combinational next-PC computation SHALL be a sub-module next_pc_logic, with inputs pc_plus4, instr, branch, jump, zero and output next_pc.
REQ-038 The FSM, PC register, instruction register and counter SHALL reside in fetch_unit.

Verification
REQ-039 Reset then sequential fetch: imem_ready=1 always, exec_done pulsed each EXEC, branch=jump=0 -> imem_addr sequence 0,4,8,C; instr_count=3 after third exec_done.
REQ-040 Taken branch: PC=0x10, instr=0x1000_FFFE, branch=1, zero=1, exec_done -> next PC=0x0C; with zero=0 -> next PC=0x14.
REQ-041 Jump with branch also set: PC=0x4000_0020, instr=0x0C00_0100, jump=1, branch=1, zero=1 -> next PC=0x4000_0400; pc_plus4=0x4000_0024 during EXEC.
REQ-042 Wait states: imem_ready held 0 for 3 cycles in FETCH -> imem_req=1 and imem_addr constant throughout; instr loaded only on the ready cycle.
REQ-043 Wrap and spurious inputs: PC=0xFFFF_FFFC, no branch -> next PC=0; exec_done pulsed in FETCH -> no PC or count change.
REQ-044 Reset mid-EXEC: rst and exec_done both 1 -> PC=RESET_PC, instr_count=0, instr_valid=0 next cycle.
